// File: rtl/pcie_mem_arbiter.sv
// Round-robin two-port arbiter for the shared PCIe memory channel.
// Requests are locked per sequence; an owner FIFO routes responses back in issue order.
module pcie_mem_arbiter #(
  parameter int OUTSTANDING = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_req_valid,
  output logic        o_m0_req_ready,
  input  logic        i_m0_req_write,
  input  logic [9:0]  i_m0_req_bytes,
  input  logic [12:0] i_m0_req_addr,
  input  logic [7:0]  i_m0_req_strob,
  input  logic [63:0] i_m0_req_data,
  input  logic        i_m0_req_last,
  output logic        o_m0_resp_valid,
  input  logic        i_m0_resp_ready,
  output logic        o_m0_resp_last,
  output logic        o_m0_resp_fault,
  output logic [12:0] o_m0_resp_addr,
  output logic [63:0] o_m0_resp_data,
  input  logic        i_m1_req_valid,
  output logic        o_m1_req_ready,
  input  logic        i_m1_req_write,
  input  logic [9:0]  i_m1_req_bytes,
  input  logic [12:0] i_m1_req_addr,
  input  logic [7:0]  i_m1_req_strob,
  input  logic [63:0] i_m1_req_data,
  input  logic        i_m1_req_last,
  output logic        o_m1_resp_valid,
  input  logic        i_m1_resp_ready,
  output logic        o_m1_resp_last,
  output logic        o_m1_resp_fault,
  output logic [12:0] o_m1_resp_addr,
  output logic [63:0] o_m1_resp_data,
  input  logic        i_req_mem_ready,
  output logic        o_req_mem_valid,
  output logic        o_req_mem_write,
  output logic [9:0]  o_req_mem_bytes,
  output logic [12:0] o_req_mem_addr,
  output logic [7:0]  o_req_mem_strob,
  output logic [63:0] o_req_mem_data,
  output logic        o_req_mem_last,
  input  logic        i_resp_mem_valid,
  input  logic        i_resp_mem_last,
  input  logic        i_resp_mem_fault,
  input  logic [12:0] i_resp_mem_addr,
  input  logic [63:0] i_resp_mem_data,
  output logic        o_resp_mem_ready,
  output logic [4:0]  o_outstanding,
  output logic        o_resp_unexpected
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  logic                   r_lock_valid;
  logic                   r_lock_owner;
  logic                   r_rr;
  logic [OUTSTANDING-1:0] r_owner;
  logic [PW-1:0]          r_wptr;
  logic [PW-1:0]          r_rptr;
  logic [4:0]             r_count;

  logic w_full, w_empty, w_sel_any, w_sel, w_sel_valid;
  logic w_accept, w_push, w_pop, w_head;

  assign w_full  = (r_count == 5'(OUTSTANDING));
  assign w_empty = (r_count == 5'd0);

  always_comb begin
    w_sel_any = 1'b1;
    w_sel     = r_rr;
    if (r_lock_valid) begin
      w_sel = r_lock_owner;
    end else if (i_m0_req_valid ^ i_m1_req_valid) begin
      w_sel = i_m1_req_valid;
    end else if (!i_m0_req_valid) begin
      w_sel_any = 1'b0;
    end
  end

  assign w_sel_valid = w_sel ? i_m1_req_valid : i_m0_req_valid;

  assign o_req_mem_valid = !i_rst & w_sel_any & w_sel_valid & !w_full;
  assign o_m0_req_ready  = !i_rst & w_sel_any & !w_sel & i_req_mem_ready & !w_full;
  assign o_m1_req_ready  = !i_rst & w_sel_any &  w_sel & i_req_mem_ready & !w_full;

  assign o_req_mem_write = w_sel ? i_m1_req_write : i_m0_req_write;
  assign o_req_mem_bytes = w_sel ? i_m1_req_bytes : i_m0_req_bytes;
  assign o_req_mem_addr  = w_sel ? i_m1_req_addr  : i_m0_req_addr;
  assign o_req_mem_strob = w_sel ? i_m1_req_strob : i_m0_req_strob;
  assign o_req_mem_data  = w_sel ? i_m1_req_data  : i_m0_req_data;
  assign o_req_mem_last  = w_sel ? i_m1_req_last  : i_m0_req_last;

  assign w_accept = o_req_mem_valid & i_req_mem_ready;
  assign w_push   = w_accept & o_req_mem_last;
  assign w_head   = r_owner[r_rptr];

  // Response fields are broadcast; only the head owner sees valid.
  assign o_m0_resp_valid = !i_rst & i_resp_mem_valid & !w_empty & !w_head;
  assign o_m1_resp_valid = !i_rst & i_resp_mem_valid & !w_empty &  w_head;
  assign o_resp_mem_ready = !i_rst & (w_empty | (w_head ? i_m1_resp_ready : i_m0_resp_ready));
  assign o_resp_unexpected = !i_rst & i_resp_mem_valid & w_empty;
  assign w_pop = i_resp_mem_valid & !w_empty & o_resp_mem_ready & i_resp_mem_last;

  assign o_m0_resp_last  = i_resp_mem_last;
  assign o_m0_resp_fault = i_resp_mem_fault;
  assign o_m0_resp_addr  = i_resp_mem_addr;
  assign o_m0_resp_data  = i_resp_mem_data;
  assign o_m1_resp_last  = i_resp_mem_last;
  assign o_m1_resp_fault = i_resp_mem_fault;
  assign o_m1_resp_addr  = i_resp_mem_addr;
  assign o_m1_resp_data  = i_resp_mem_data;
  assign o_outstanding   = r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lock_valid <= 1'b0;
      r_lock_owner <= 1'b0;
      r_rr         <= 1'b0;
      r_owner      <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
    end else begin
      if (w_accept) begin
        if (o_req_mem_last) begin
          r_lock_valid <= 1'b0;
          r_rr         <= ~w_sel;
        end else begin
          r_lock_valid <= 1'b1;
          r_lock_owner <= w_sel;
        end
      end
      if (w_push) begin
        r_owner[r_wptr] <= w_sel;
        r_wptr          <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 5'd1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_pcie_mem_arbiter.sv
// Bench for pcie_mem_arbiter: directed scenarios followed by random traffic,
// each cycle compared against a queue-based model of the arbitration rules.
module tb_pcie_mem_arbiter;

  localparam int OUTSTANDING = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        rv [2];
  logic        rw [2];
  logic        rl [2];
  logic [9:0]  rb [2];
  logic [12:0] ra [2];
  logic [7:0]  rs [2];
  logic [63:0] rd [2];
  logic        prr [2];
  logic        mem_rdy, mv, ml, mf;
  logic [12:0] maddr;
  logic [63:0] mdata;

  logic        rdy0, rdy1, pv0, pv1, pl0, pl1, pf0, pf1;
  logic [12:0] pa0, pa1;
  logic [63:0] pd0, pd1;
  logic        qv, qw, ql, resp_rdy, unexp;
  logic [9:0]  qb;
  logic [12:0] qa;
  logic [7:0]  qs;
  logic [63:0] qd;
  logic [4:0]  outst;

  pcie_mem_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req_valid(rv[0]), .o_m0_req_ready(rdy0), .i_m0_req_write(rw[0]),
    .i_m0_req_bytes(rb[0]), .i_m0_req_addr(ra[0]), .i_m0_req_strob(rs[0]),
    .i_m0_req_data(rd[0]), .i_m0_req_last(rl[0]),
    .o_m0_resp_valid(pv0), .i_m0_resp_ready(prr[0]), .o_m0_resp_last(pl0),
    .o_m0_resp_fault(pf0), .o_m0_resp_addr(pa0), .o_m0_resp_data(pd0),
    .i_m1_req_valid(rv[1]), .o_m1_req_ready(rdy1), .i_m1_req_write(rw[1]),
    .i_m1_req_bytes(rb[1]), .i_m1_req_addr(ra[1]), .i_m1_req_strob(rs[1]),
    .i_m1_req_data(rd[1]), .i_m1_req_last(rl[1]),
    .o_m1_resp_valid(pv1), .i_m1_resp_ready(prr[1]), .o_m1_resp_last(pl1),
    .o_m1_resp_fault(pf1), .o_m1_resp_addr(pa1), .o_m1_resp_data(pd1),
    .i_req_mem_ready(mem_rdy), .o_req_mem_valid(qv), .o_req_mem_write(qw),
    .o_req_mem_bytes(qb), .o_req_mem_addr(qa), .o_req_mem_strob(qs),
    .o_req_mem_data(qd), .o_req_mem_last(ql),
    .i_resp_mem_valid(mv), .i_resp_mem_last(ml), .i_resp_mem_fault(mf),
    .i_resp_mem_addr(maddr), .i_resp_mem_data(mdata),
    .o_resp_mem_ready(resp_rdy), .o_outstanding(outst), .o_resp_unexpected(unexp)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: owner queue, current lock holder (-1 = none), preferred port.
  int q[$];
  int lock_o = -1;
  int pref   = 0;
  bit e_acc, e_last, e_pop;
  int e_g;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    bit full, empty, ev;
    int g, head;
    full  = (q.size() == OUTSTANDING);
    empty = (q.size() == 0);
    if (lock_o >= 0)          g = lock_o;
    else if (rv[0] && !rv[1]) g = 0;
    else if (rv[1] && !rv[0]) g = 1;
    else if (rv[0] && rv[1])  g = pref;
    else                      g = -1;
    ev = (g >= 0) && rv[g] && !full;
    chk("req_valid", qv, ev);
    chk("m0_req_ready", rdy0, (g == 0) && mem_rdy && !full);
    chk("m1_req_ready", rdy1, (g == 1) && mem_rdy && !full);
    if (ev) begin
      chk("req_addr", qa, ra[g]);
      chk("req_data", qd, rd[g]);
      chk("req_bytes", qb, rb[g]);
      chk("req_strob", qs, rs[g]);
      chk("req_write", qw, rw[g]);
      chk("req_last", ql, rl[g]);
    end
    head = empty ? -1 : q[0];
    chk("m0_resp_valid", pv0, mv && (head == 0));
    chk("m1_resp_valid", pv1, mv && (head == 1));
    chk("resp_mem_ready", resp_rdy, empty ? 1'b1 : prr[head]);
    chk("resp_unexpected", unexp, mv && empty);
    chk("outstanding", outst, q.size());
    if (mv && head == 0) chk("m0_resp_data", pd0, mdata);
    if (mv && head == 1) chk("m1_resp_data", pd1, mdata);
    e_acc  = ev && mem_rdy;
    e_g    = g;
    e_last = (g >= 0) ? rl[g] : 1'b0;
    e_pop  = mv && !empty && prr[head] && ml;
  endtask

  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    if (e_pop) void'(q.pop_front());
    if (e_acc) begin
      if (e_last) begin
        q.push_back(e_g);
        lock_o = -1;
        pref   = 1 - e_g;
      end else begin
        lock_o = e_g;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      rv[k] = 0; rw[k] = 0; rl[k] = 0; rb[k] = 10'(k + 8);
      ra[k] = 13'(16 * k); rs[k] = 8'hFF; rd[k] = 64'(k); prr[k] = 1;
    end
    mem_rdy = 1; mv = 0; ml = 0; mf = 0; maddr = 0; mdata = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    chk("rst_req_valid", qv, 0);
    chk("rst_m0_ready", rdy0, 0);
    chk("rst_m1_ready", rdy1, 0);
    chk("rst_m0_resp_valid", pv0, 0);
    chk("rst_m1_resp_valid", pv1, 0);
    chk("rst_resp_ready", resp_rdy, 0);
    chk("rst_unexpected", unexp, 0);
    q.delete(); lock_o = -1; pref = 0;
    @(negedge clk); @(negedge clk);
    rst = 0;
    idle();
  endtask

  initial begin
    idle();
    rv[0] = 1; rv[1] = 1; mv = 1;
    #2;
    do_reset();
    chk("reset_outstanding", outst, 0);

    // Continuous single-beat requests alternate from m0 until the FIFO fills.
    rv[0] = 1; rv[1] = 1; rl[0] = 1; rl[1] = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_m0_grant", rdy0, (i % 2) == 0);
      chk("alt_m1_grant", rdy1, (i % 2) == 1);
      step();
    end
    #1; chk("full_m0_ready", rdy0, 0); chk("full_m1_ready", rdy1, 0); chk("full_count", outst, 4);
    step();
    mv = 1; ml = 1; mdata = 64'hA5;
    #1; chk("full_pop_m0_ready", rdy0, 0); chk("full_pop_route", pv0, 1);
    step();
    mv = 0;
    #1; chk("after_pop_ready", rdy0, 1);
    step();
    rv[0] = 0; rv[1] = 0;
    for (int i = 0; i < 4; i++) begin
      mv = 1; ml = 1; mdata = 64'(i);
      #1; chk("order_m1", pv1, (i % 2) == 0); chk("order_m0", pv0, (i % 2) == 1);
      step();
    end
    mv = 0;
    step();

    // Single read from port 0.
    rv[0] = 1; rw[0] = 0; rl[0] = 1; ra[0] = 13'h010;
    #1; chk("rd_addr", qa, 13'h010); chk("rd_valid", qv, 1);
    step();
    rv[0] = 0;
    #1; chk("rd_outstanding", outst, 1);
    step();
    mv = 1; ml = 1; mdata = 64'h1122334455667788;
    #1; chk("rd_resp_v0", pv0, 1); chk("rd_resp_v1", pv1, 0); chk("rd_resp_data", pd0, 64'h1122334455667788);
    step();
    mv = 0;
    #1; chk("rd_done_outstanding", outst, 0);
    step();

    // Response beat with nothing outstanding.
    mv = 1; ml = 1;
    #1; chk("unexp_ready", resp_rdy, 1); chk("unexp_pulse", unexp, 1);
    chk("unexp_v0", pv0, 0); chk("unexp_v1", pv1, 0);
    step();
    mv = 0;
    #1; chk("unexp_once", unexp, 0);
    step();

    // Three-beat write from port 0 while port 1 waits.
    rv[0] = 1; rw[0] = 1; rl[0] = 0; rd[0] = 64'hD0;
    step();
    rv[1] = 1; rl[1] = 1; rd[0] = 64'hD1;
    #1; chk("lock_m0_beat2", rdy0, 1); chk("lock_m1_wait2", rdy1, 0);
    step();
    rl[0] = 1; rd[0] = 64'hD2;
    #1; chk("lock_m0_beat3", rdy0, 1); chk("lock_m1_wait3", rdy1, 0);
    step();
    rv[0] = 0;
    #1; chk("lock_m1_granted", rdy1, 1);
    step();
    rv[1] = 0; mv = 1; ml = 1;
    step(); step();
    mv = 0;

    // Reset in the middle of a sequence with two reads outstanding.
    rv[0] = 1; rw[0] = 0; rl[0] = 1;
    step();
    rv[0] = 0; rv[1] = 1; rl[1] = 1;
    step();
    rv[1] = 0; rv[0] = 1; rw[0] = 1; rl[0] = 0;
    step(); step();
    mv = 1;
    do_reset();
    rv[0] = 1; rv[1] = 1; rl[0] = 1; rl[1] = 1;
    #1; chk("post_rst_outstanding", outst, 0); chk("post_rst_pref", rdy0, 1);
    step();
    idle();
    mv = 1; ml = 1;
    step();
    idle();
    step();

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      for (int k = 0; k < 2; k++) begin
        rv[k] = ($urandom_range(0, 3) != 0);
        rw[k] = $urandom_range(0, 1);
        rl[k] = ($urandom_range(0, 2) == 0);
        rb[k] = 10'($urandom);
        ra[k] = 13'($urandom);
        rs[k] = 8'($urandom);
        rd[k] = {$urandom, $urandom};
        prr[k] = ($urandom_range(0, 3) != 0);
      end
      mem_rdy = ($urandom_range(0, 3) != 0);
      mv = $urandom_range(0, 1);
      ml = $urandom_range(0, 1);
      mf = $urandom_range(0, 1);
      maddr = 13'($urandom);
      mdata = {$urandom, $urandom};
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcie_mem_arbiter.md
# pcie_mem_arbiter

Two-requester arbiter that shares the single PCIe-side memory request/response channel between the PCIe I/O endpoint (port 0) and a second local master such as a DMA or debug engine (port 1). Arbitration is round-robin at sequence granularity: a sequence of request beats ends with `last` and is never interleaved with the other port. An in-order owner FIFO routes each response sequence back to the port that issued the matching request sequence. The block sits between the endpoint and the memory/bridge slave.

## Interface
- `OUTSTANDING`, 4: owner FIFO depth, meaning the maximum number of request sequences awaiting a response sequence. Power of two, 2..16.
- `i_clk`  in  1  system bus clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_mK_req_valid`/`o_mK_req_ready`  in/out  1  request handshake for port K=0,1.
- `i_mK_req_write`  in  1  0 = read, 1 = write.
- `i_mK_req_bytes`  in  10  byte count (0 = 1024 B).
- `i_mK_req_addr`  in  13  address.
- `i_mK_req_strob`  in  8  write byte enables.
- `i_mK_req_data`  in  64  write data.
- `i_mK_req_last`  in  1  last beat of a request sequence.
- `o_mK_resp_valid`/`i_mK_resp_ready`  out/in  1  response handshake for port K.
- `o_mK_resp_last`  out  1  last response beat.
- `o_mK_resp_fault`  out  1  access error.
- `o_mK_resp_addr`  out  13  response address.
- `o_mK_resp_data`  out  64  response data.
- `i_req_mem_ready`  in  1  downstream request handshake ready.
- `o_req_mem_valid`  out  1  downstream request handshake valid.
- `o_req_mem_write`, `o_req_mem_bytes[9:0]`, `o_req_mem_addr[12:0]`, `o_req_mem_strob[7:0]`, `o_req_mem_data[63:0]`, `o_req_mem_last`  out  muxed request fields.
- `i_resp_mem_valid`, `i_resp_mem_last`, `i_resp_mem_fault`, `i_resp_mem_addr[12:0]`, `i_resp_mem_data[63:0]`  in  downstream response.
- `o_resp_mem_ready`  out  1  downstream response ready.
- `o_outstanding`  out  5  current owner FIFO occupancy.
- `o_resp_unexpected`  out  1  one-cycle pulse when a response beat arrives with the FIFO empty.

## Operation
- State registers:
  - `lock_valid`, `lock_owner`: sequence lock.
  - `rr`: preferred port.
  - Owner FIFO, 1-bit entries: write pointer, read pointer, count.
- Port selection `sel`:
  - If `lock_valid`, `sel = lock_owner`.
  - Else if exactly one port is valid, `sel` is that port.
  - Else if both ports are valid, `sel = rr`.
  - Else no port is selected.
- Request mux:
  - `o_req_mem_*` carries the fields of port `sel`.
  - `o_req_mem_valid = i_m<sel>_req_valid & !fifo_full`.
  - `o_m<sel>_req_ready = i_req_mem_ready & !fifo_full`.
  - The unselected port's ready is 0.
- Accept means `o_req_mem_valid & i_req_mem_ready`. On accept:
  - `last=0`: set `lock_valid=1`, `lock_owner=sel`.
  - `last=1`: clear `lock_valid`, push `sel` into the FIFO, set `rr = ~sel`.
- FIFO full blocks all new request beats, including beats of a locked sequence. The push only happens at `last`, so while a sequence is in progress the occupancy is at most `OUTSTANDING-1`, and full can only block at a sequence boundary.
- Response routing, with `head` = FIFO read entry:
  - `o_m<head>_resp_valid = i_resp_mem_valid & !fifo_empty`; response fields are broadcast to both ports.
  - The other port's `resp_valid` is 0.
  - `o_resp_mem_ready = i_m<head>_resp_ready`.
  - Pop on `i_resp_mem_valid & o_resp_mem_ready & i_resp_mem_last`.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance. A push into a FIFO that was empty is routable from the next cycle only.
- Unexpected response (`i_resp_mem_valid` with FIFO empty):
  - `o_resp_mem_ready=1`, so the beat is dropped.
  - `o_resp_unexpected` pulses for that cycle.
  - No port sees valid.

## Timing
- Request path: combinational, zero added latency. No output register.
- Response path: combinational, zero added latency.
- Owner state updates on the `i_clk` rising edge after a handshake.
- Reset (asynchronous, `i_rst=1`) clears `lock_valid`, sets `rr=0`, empties the FIFO and sets `o_outstanding=0`.
- While `i_rst=1`, every valid/ready output and `o_resp_unexpected` is forced to 0; data fields are don't-care.
- Reset mid-sequence discards the lock and all outstanding routing. Masters must be reset together with this block.
- Sustained throughput: one beat per cycle per direction. Back-to-back sequences from alternating ports have no bubble.

## Test plan
- Single read from port 0 (`addr=0x010`, `last=1`):
  - Request appears on `o_req_mem_*` in the same cycle.
  - `o_outstanding` becomes 1.
  - Response with `data=0x1122334455667788` and `last=1` reaches `o_m0_resp_*` only.
  - `o_outstanding` returns to 0.
- Both ports valid continuously, every sequence 1 beat: grants alternate m0, m1, m0, m1 starting with m0 after reset.
- Port 0 issues a 3-beat write while port 1 is valid from the second cycle: all 3 beats of port 0 complete first, then port 1 is granted the cycle after port 0's `last`.
- With `OUTSTANDING=4`:
  - Issue 4 single-beat reads with no responses: the 5th request sees ready=0.
  - Return one response with `last=1`: the 5th request is accepted the next cycle.
  - Responses route in issue order (owners 0,1,0,1).
- Response beat with the FIFO empty: `o_resp_mem_ready=1`, `o_resp_unexpected` pulses once, both `o_mK_resp_valid` stay 0.
- Assert `i_rst` mid 3-beat sequence with 2 reads outstanding:
  - All outputs go to 0 immediately.
  - After release, `o_outstanding=0` and port 0 is preferred.
